parking_slot_manager: RTL and testbench

Registered, parametrised successor to the combinational parking-capacity update. It holds the occupancy bitmap of NUM_SLOTS parking places in a register. It allocates the lowest-index free slot on a car-entry request and releases a named slot on a car-exit request. It maintains a free-slot counter and full/empty flags, and sits between the gate sensors and the display/billing logic.

---
 rtl/parking_pkg.sv | 19 +
 rtl/lowest_free_finder.sv | 21 ++
 rtl/parking_slot_manager.sv | 90 +++++++++
 tb/tb_parking_slot_manager.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking slot manager.
package parking_pkg;

  localparam int unsigned DEFAULT_NUM_SLOTS = 8;

  function automatic logic is_onehot(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_free_finder.sv
// Combinational priority encoder: one-hot mask of the lowest zero bit in the occupancy map.
module lowest_free_finder #(
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic [NUM_SLOTS-1:0] i_occupancy,
  output logic                 o_found,
  output logic [NUM_SLOTS-1:0] o_mask
);

  always_comb begin
    o_found = 1'b0;
    o_mask  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!i_occupancy[i] && !o_found) begin
        o_found   = 1'b1;
        o_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Registered parking occupancy tracker: allocates lowest free slot on entry, releases a named slot on exit.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [NUM_SLOTS-1:0] exit_slot,
  output logic                 enter_ack,
  output logic                 enter_nack,
  output logic [NUM_SLOTS-1:0] enter_slot,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty
);

  logic [NUM_SLOTS-1:0] r_occupancy;
  logic [CNT_W-1:0]     r_free_count;
  logic                 r_enter_ack;
  logic                 r_enter_nack;
  logic [NUM_SLOTS-1:0] r_enter_slot;
  logic                 r_exit_err;

  logic                 w_found;
  logic [NUM_SLOTS-1:0] w_lowest;
  logic                 w_exit_legal;
  logic                 w_enter_ok;
  logic [NUM_SLOTS-1:0] w_exit_mask;
  logic [NUM_SLOTS-1:0] w_enter_mask;
  logic [NUM_SLOTS-1:0] w_occ_next;
  logic [CNT_W-1:0]     w_cnt_next;

  lowest_free_finder #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_finder (
    .i_occupancy(r_occupancy),
    .o_found    (w_found),
    .o_mask     (w_lowest)
  );

  // Entry and exit both judged against the pre-update bitmap, so a slot freed
  // this cycle cannot be handed out until the next one.
  always_comb begin
    w_exit_legal = exit_req && is_onehot(64'(exit_slot)) && ((r_occupancy & exit_slot) != '0);
    w_enter_ok   = enter_req && w_found;
    w_exit_mask  = w_exit_legal ? exit_slot : '0;
    w_enter_mask = w_enter_ok ? w_lowest : '0;
    w_occ_next   = (r_occupancy & ~w_exit_mask) | w_enter_mask;
    w_cnt_next   = r_free_count;
    unique case ({w_enter_ok, w_exit_legal})
      2'b10:   w_cnt_next = r_free_count - CNT_W'(1);
      2'b01:   w_cnt_next = r_free_count + CNT_W'(1);
      default: w_cnt_next = r_free_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occupancy  <= '0;
      r_free_count <= CNT_W'(NUM_SLOTS);
      r_enter_ack  <= 1'b0;
      r_enter_nack <= 1'b0;
      r_enter_slot <= '0;
      r_exit_err   <= 1'b0;
    end else begin
      r_occupancy  <= w_occ_next;
      r_free_count <= w_cnt_next;
      r_enter_ack  <= w_enter_ok;
      r_enter_nack <= enter_req && !w_found;
      r_enter_slot <= w_enter_mask;
      r_exit_err   <= exit_req && !w_exit_legal;
    end
  end

  assign occupancy  = r_occupancy;
  assign free_count = r_free_count;
  assign enter_ack  = r_enter_ack;
  assign enter_nack = r_enter_nack;
  assign enter_slot = r_enter_slot;
  assign exit_err   = r_exit_err;
  assign full       = (r_free_count == '0);
  assign empty      = (r_free_count == CNT_W'(NUM_SLOTS));

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench for parking_slot_manager with an independent reference model.
module tb_parking_slot_manager;
  import parking_pkg::*;

  localparam int unsigned NS = 8;

  logic          clk;
  logic          rst;
  logic          enter_req;
  logic          exit_req;
  logic [NS-1:0] exit_slot;
  logic          enter_ack;
  logic          enter_nack;
  logic [NS-1:0] enter_slot;
  logic          exit_err;
  logic [NS-1:0] occupancy;
  logic [3:0]    free_count;
  logic          full;
  logic          empty;

  parking_slot_manager #(
    .NUM_SLOTS(NS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enter_req (enter_req),
    .exit_req  (exit_req),
    .exit_slot (exit_slot),
    .enter_ack (enter_ack),
    .enter_nack(enter_nack),
    .enter_slot(enter_slot),
    .exit_err  (exit_err),
    .occupancy (occupancy),
    .free_count(free_count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          ack;
    logic          nack;
    logic          err;
    logic [NS-1:0] slot;
    logic [NS-1:0] occ;
    logic [3:0]    cnt;
    logic          full;
    logic          empty;
  } exp_t;

  exp_t          sb_q[$];
  logic [NS-1:0] m_occ;
  int unsigned   n_checks;
  int unsigned   n_errors;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !$isunknown(free_count))
      assert (32'(free_count) == NS - popcount(64'(occupancy)))
        else $error("invariant free_count=%0d occupancy=0x%0h", free_count, occupancy);
  end

  task automatic step(input logic r, input logic en, input logic ex, input logic [NS-1:0] sl);
    exp_t          e;
    exp_t          got;
    logic          legal;
    logic          fnd;
    logic [NS-1:0] lm;
    e = '0;
    if (r) begin
      m_occ = '0;
    end else begin
      fnd = 1'b0;
      lm  = '0;
      for (int i = 0; i < NS; i++) begin
        if (!fnd && !m_occ[i]) begin
          fnd   = 1'b1;
          lm[i] = 1'b1;
        end
      end
      legal  = ex && ($countones(sl) == 1) && ((m_occ & sl) != '0);
      e.ack  = en && fnd;
      e.nack = en && !fnd;
      e.err  = ex && !legal;
      e.slot = e.ack ? lm : '0;
      m_occ  = (m_occ & ~(legal ? sl : '0)) | e.slot;
    end
    e.occ   = m_occ;
    e.cnt   = 4'(NS - popcount(64'(m_occ)));
    e.full  = (e.cnt == 0);
    e.empty = (e.cnt == 4'(NS));
    sb_q.push_back(e);

    rst       = r;
    enter_req = en;
    exit_req  = ex;
    exit_slot = sl;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    enter_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;

    got = sb_q.pop_front();
    check_eq("enter_ack",  64'(enter_ack),  64'(got.ack));
    check_eq("enter_nack", 64'(enter_nack), 64'(got.nack));
    check_eq("exit_err",   64'(exit_err),   64'(got.err));
    check_eq("enter_slot", 64'(enter_slot), 64'(got.slot));
    check_eq("occupancy",  64'(occupancy),  64'(got.occ));
    check_eq("free_count", 64'(free_count), 64'(got.cnt));
    check_eq("full",       64'(full),       64'(got.full));
    check_eq("empty",      64'(empty),      64'(got.empty));
  endtask

  initial begin
    logic [NS-1:0] sl;
    n_checks  = 0;
    n_errors  = 0;
    m_occ     = '0;
    rst       = 1'b0;
    enter_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
    @(negedge clk);

    // reset with a competing entry request
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_cnt", 64'(free_count), 64'd8);

    // fill the lot
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check_eq("fill_slot", 64'(enter_slot), 64'(8'h01 << i));
    end
    check_eq("fill_full", 64'(full), 64'd1);

    // full lot refuses entry
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("full_nack", 64'(enter_nack), 64'd1);
    check_eq("full_occ", 64'(occupancy), 64'hFF);

    // full lot: simultaneous exit does not rescue the entry
    step(1'b0, 1'b1, 1'b1, 8'h10);
    check_eq("sim_occ", 64'(occupancy), 64'hEF);
    check_eq("sim_cnt", 64'(free_count), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("reuse_slot", 64'(enter_slot), 64'h10);

    // drain to 0x05, then illegal exits
    step(1'b0, 1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b0, 1'b1, 8'h80);
    check_eq("drain_occ", 64'(occupancy), 64'h05);
    step(1'b0, 1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b0, 1'b1, 8'h05);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("illegal_occ", 64'(occupancy), 64'h05);

    // build 0x0B then enter+exit together
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 8'h04);
    check_eq("pre_occ", 64'(occupancy), 64'h0B);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    check_eq("both_slot", 64'(enter_slot), 64'h04);
    check_eq("both_occ", 64'(occupancy), 64'h0E);
    check_eq("both_cnt", 64'(free_count), 64'd5);

    // build 0x3C then reset mid-operation
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 1'b1, 8'h02);
    check_eq("pre_rst_occ", 64'(occupancy), 64'h3C);
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("mid_rst_occ", 64'(occupancy), 64'h00);
    check_eq("mid_rst_ack", 64'(enter_ack), 64'd0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) sl = 8'h01 << $urandom_range(0, 7);
      else sl = 8'($urandom);
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), sl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
